// File: rtl/mem_uop_pkg.sv
// Memory uop encodings, controller state encoding and byte-lane helper shared by
// the load/store unit, the dcache and their benches.
package mem_uop_pkg;

  localparam logic [4:0] NOP_UOP  = 5'b00000;
  localparam logic [4:0] STR_UOP  = 5'b01001;
  localparam logic [4:0] LDR_UOP  = 5'b01010;
  localparam logic [4:0] STRB_UOP = 5'b01011;
  localparam logic [4:0] LDRB_UOP = 5'b01100;

  typedef enum logic [2:0] {
    IDLE,
    LD_WAIT,
    RMW_WAIT,
    RMW_WR,
    WB
  } lsu_state_t;

  // One-hot byte enable for a little-endian lane (lane 0 = bits [7:0]).
  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Issue, dcache and writeback signals of the load/store controller.
// The slave modport is the controller's view, the master modport the environment's.
interface lsu_ctrl_if;

  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_uop;
  logic [31:0] in_base;
  logic [31:0] in_offset;
  logic        in_sub;
  logic [31:0] in_wdata;
  logic [3:0]  in_rd;

  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic [4:0]  dc_uop;
  logic [31:0] dc_rdata;

  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;

  modport slave (
    input  in_valid, in_uop, in_base, in_offset, in_sub, in_wdata, in_rd, dc_rdata,
    output in_ready, dc_addr, dc_wdata, dc_uop, wb_valid, wb_rd, wb_data
  );

  modport master (
    output in_valid, in_uop, in_base, in_offset, in_sub, in_wdata, in_rd, dc_rdata,
    input  in_ready, dc_addr, dc_wdata, dc_uop, wb_valid, wb_rd, wb_data
  );

endinterface

// File: rtl/byte_lane.sv
// Combinational byte extract (zero-extended) and byte merge on a 32-bit word.
module byte_lane
  import mem_uop_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [7:0]  byte_in,
  output logic [31:0] byte_ext,
  output logic [31:0] merged
);

  logic [3:0] mask;

  always_comb begin
    mask = lane_mask(lane);
    unique case (lane)
      2'd0:    byte_ext = {24'h0, word[7:0]};
      2'd1:    byte_ext = {24'h0, word[15:8]};
      2'd2:    byte_ext = {24'h0, word[23:16]};
      default: byte_ext = {24'h0, word[31:24]};
    endcase
    merged = word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged[8*i +: 8] = byte_in;
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one memory uop, computes the effective address,
// sequences dcache accesses (read-modify-write for byte stores) and returns loads.
module lsu_ctrl
  import mem_uop_pkg::*;
#(
  parameter int DCACHE_LATENCY = 1
)
(
  input  logic        clock,
  input  logic        reset,
  lsu_ctrl_if.slave   bus
);

  lsu_state_t  state_q, state_d;

  logic [4:0]  uop_p0;
  logic [1:0]  lane_p0;
  logic [7:0]  wbyte_p0;
  logic [3:0]  rd_p0;
  logic [2:0]  cnt_p0;

  logic        accept;
  logic        wait_done;
  logic [31:0] ea;
  logic [31:0] rd_byte;
  logic [31:0] merged;

  logic        in_ready_d;
  logic [4:0]  dc_uop_d;
  logic [31:0] dc_addr_d;
  logic [31:0] dc_wdata_d;
  logic        wb_valid_d;
  logic [3:0]  wb_rd_d;
  logic [31:0] wb_data_d;

  assign accept    = bus.in_valid && bus.in_ready;
  assign ea        = bus.in_sub ? bus.in_base - bus.in_offset : bus.in_base + bus.in_offset;
  assign wait_done = (cnt_p0 == 3'(DCACHE_LATENCY));

  byte_lane u_lane (
    .word     (bus.dc_rdata),
    .lane     (lane_p0),
    .byte_in  (wbyte_p0),
    .byte_ext (rd_byte),
    .merged   (merged)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.in_uop == LDR_UOP || bus.in_uop == LDRB_UOP) state_d = LD_WAIT;
          else if (bus.in_uop == STR_UOP)                      state_d = RMW_WR;
          else if (bus.in_uop == STRB_UOP)                     state_d = RMW_WAIT;
        end
      end
      LD_WAIT:  if (wait_done) state_d = WB;
      RMW_WAIT: if (wait_done) state_d = RMW_WR;
      RMW_WR:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; unused opcodes leave everything untouched.
  always_comb begin
    in_ready_d = (state_d == IDLE);
    dc_uop_d   = NOP_UOP;
    dc_addr_d  = bus.dc_addr;
    dc_wdata_d = bus.dc_wdata;
    wb_valid_d = 1'b0;
    wb_rd_d    = bus.wb_rd;
    wb_data_d  = bus.wb_data;
    unique case (state_q)
      IDLE: begin
        if (accept && state_d != IDLE) begin
          dc_addr_d = {ea[31:2], 2'b00};
          if (bus.in_uop == STR_UOP) begin
            dc_uop_d   = STR_UOP;
            dc_wdata_d = bus.in_wdata;
          end else begin
            dc_uop_d   = LDR_UOP;
          end
        end
      end
      LD_WAIT: begin
        if (wait_done) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_p0;
          wb_data_d  = (uop_p0 == LDRB_UOP) ? rd_byte : bus.dc_rdata;
        end
      end
      RMW_WAIT: begin
        if (wait_done) begin
          dc_uop_d   = STR_UOP;
          dc_wdata_d = merged;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.in_ready <= 1'b1;
      bus.dc_uop   <= NOP_UOP;
      bus.dc_addr  <= '0;
      bus.dc_wdata <= '0;
      bus.wb_valid <= 1'b0;
      bus.wb_rd    <= '0;
      bus.wb_data  <= '0;
      cnt_p0       <= '0;
    end else begin
      bus.in_ready <= in_ready_d;
      bus.dc_uop   <= dc_uop_d;
      bus.dc_addr  <= dc_addr_d;
      bus.dc_wdata <= dc_wdata_d;
      bus.wb_valid <= wb_valid_d;
      bus.wb_rd    <= wb_rd_d;
      bus.wb_data  <= wb_data_d;
      if (accept)
        cnt_p0 <= '0;
      else if ((state_q == LD_WAIT || state_q == RMW_WAIT) && !wait_done)
        cnt_p0 <= cnt_p0 + 3'd1;
    end
  end

  // Request capture on the accept edge; held while busy.
  always_ff @(posedge clock) begin
    if (accept) begin
      uop_p0   <= bus.in_uop;
      lane_p0  <= ea[1:0];
      wbyte_p0 <= bus.in_wdata[7:0];
      rd_p0    <= bus.in_rd;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: two instances (dcache latency 1 and 3), each with a
// small behavioural dcache, a table of single-uop vectors and hand-written corner sequences.
module tb_lsu_ctrl;
  import mem_uop_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lsu_ctrl_if if1();
  lsu_ctrl_if if3();

  lsu_ctrl #(.DCACHE_LATENCY(1)) dut1 (.clock(clock), .reset(reset), .bus(if1));
  lsu_ctrl #(.DCACHE_LATENCY(3)) dut3 (.clock(clock), .reset(reset), .bus(if3));

  // Behavioural dcaches: a store lands at the edge that sees it, read data
  // appears LATENCY cycles after the address is presented.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [7:0]  rp1;
  logic [7:0]  rp3 [3];

  always @(posedge clock) begin
    if (if1.dc_uop == STR_UOP) mem1[if1.dc_addr[9:2]] <= if1.dc_wdata;
    rp1 <= if1.dc_addr[9:2];
    if (if3.dc_uop == STR_UOP) mem3[if3.dc_addr[9:2]] <= if3.dc_wdata;
    rp3[0] <= if3.dc_addr[9:2];
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign if1.dc_rdata = mem1[rp1];
  assign if3.dc_rdata = mem3[rp3[2]];

  int ld1 = 0, st1 = 0, wb1 = 0, st3 = 0;
  logic [31:0] addr1 = '0, sdat1 = '0, wdat1 = '0;
  logic [3:0]  wrd1 = '0;

  always @(negedge clock) begin
    if (if1.dc_uop == LDR_UOP) begin ld1 <= ld1 + 1; addr1 <= if1.dc_addr; end
    if (if1.dc_uop == STR_UOP) begin st1 <= st1 + 1; addr1 <= if1.dc_addr; sdat1 <= if1.dc_wdata; end
    if (if1.wb_valid) begin wb1 <= wb1 + 1; wdat1 <= if1.wb_data; wrd1 <= if1.wb_rd; end
    if (if3.dc_uop == STR_UOP) st3 <= st3 + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic v, input logic [4:0] u, input logic [31:0] b,
                       input logic [31:0] o, input logic sb, input logic [31:0] w, input logic [3:0] r);
    if (s == 1) begin
      if1.in_valid = v; if1.in_uop = u; if1.in_base = b; if1.in_offset = o;
      if1.in_sub = sb; if1.in_wdata = w; if1.in_rd = r;
    end else begin
      if3.in_valid = v; if3.in_uop = u; if3.in_base = b; if3.in_offset = o;
      if3.in_sub = sb; if3.in_wdata = w; if3.in_rd = r;
    end
  endtask

  function automatic logic rdy(input int s);
    return (s == 1) ? if1.in_ready : if3.in_ready;
  endfunction

  // Offers one uop and returns on the falling edge just after it is accepted.
  task automatic issue(input int s, input logic [4:0] u, input logic [31:0] b, input logic [31:0] o,
                       input logic sb, input logic [31:0] w, input logic [3:0] r);
    int n = 0;
    while (!rdy(s) && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(rdy(s)), 32'd1);
    drive(s, 1'b1, u, b, o, sb, w, r);
    @(negedge clock);
    drive(s, 1'b0, NOP_UOP, '0, '0, 1'b0, '0, '0);
  endtask

  typedef struct {
    logic [4:0]  uop;
    logic [31:0] base;
    logic [31:0] off;
    logic        sub;
    logic [31:0] wdata;
    logic [3:0]  rd;
    int          n_ld;
    int          n_st;
    int          n_wb;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic [31:0] wb_data;
  } vec_t;

  vec_t vt[14];

  task automatic run_vec(input int i);
    vec_t v;
    int l0, s0, w0;
    v  = vt[i];
    l0 = ld1; s0 = st1; w0 = wb1;
    issue(1, v.uop, v.base, v.off, v.sub, v.wdata, v.rd);
    chk($sformatf("v%0d_ready", i), 32'(if1.in_ready), 32'((v.n_ld + v.n_st) == 0));
    repeat (6) @(negedge clock);
    chk($sformatf("v%0d_nld", i), 32'(ld1 - l0), 32'(v.n_ld));
    chk($sformatf("v%0d_nst", i), 32'(st1 - s0), 32'(v.n_st));
    chk($sformatf("v%0d_nwb", i), 32'(wb1 - w0), 32'(v.n_wb));
    if (v.n_ld + v.n_st > 0) chk($sformatf("v%0d_addr", i), addr1, v.addr);
    if (v.n_st > 0)          chk($sformatf("v%0d_stdata", i), sdat1, v.st_data);
    if (v.n_wb > 0) begin
      chk($sformatf("v%0d_wbdata", i), wdat1, v.wb_data);
      chk($sformatf("v%0d_wbrd", i), 32'(wrd1), 32'(v.rd));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] uops [6];
    logic       rdys [6];
    int         s0;

    //         uop       base          off     sub   wdata         rd  ld st wb addr          st_data       wb_data
    vt[0]  = '{STR_UOP,  32'h100,      32'h8,  1'b0, 32'h12345678, 0,  0, 1, 0, 32'h108,      32'h12345678, 32'h0};
    vt[1]  = '{LDR_UOP,  32'h100,      32'h8,  1'b0, 32'h0,        5,  1, 0, 1, 32'h108,      32'h0,        32'h12345678};
    vt[2]  = '{STR_UOP,  32'h20,       32'h4,  1'b1, 32'hDEADBEEF, 0,  0, 1, 0, 32'h1C,       32'hDEADBEEF, 32'h0};
    vt[3]  = '{LDR_UOP,  32'h1C,       32'h0,  1'b0, 32'h0,        3,  1, 0, 1, 32'h1C,       32'h0,        32'hDEADBEEF};
    vt[4]  = '{STR_UOP,  32'h40,       32'h0,  1'b0, 32'hAABBCCDD, 0,  0, 1, 0, 32'h40,       32'hAABBCCDD, 32'h0};
    vt[5]  = '{STRB_UOP, 32'h40,       32'h2,  1'b0, 32'hFFFFFF11, 0,  1, 1, 0, 32'h40,       32'hAA11CCDD, 32'h0};
    vt[6]  = '{LDRB_UOP, 32'h40,       32'h3,  1'b0, 32'h0,        7,  1, 0, 1, 32'h40,       32'h0,        32'h000000AA};
    vt[7]  = '{5'b00010, 32'h40,       32'h0,  1'b0, 32'hDEADBEEF, 9,  0, 0, 0, 32'h0,        32'h0,        32'h0};
    vt[8]  = '{LDR_UOP,  32'h40,       32'h0,  1'b0, 32'h0,        1,  1, 0, 1, 32'h40,       32'h0,        32'hAA11CCDD};
    vt[9]  = '{STR_UOP,  32'hFFFFFFFC, 32'h8,  1'b0, 32'hCAFEF00D, 0,  0, 1, 0, 32'h4,        32'hCAFEF00D, 32'h0};
    vt[10] = '{LDR_UOP,  32'h8,        32'h4,  1'b1, 32'h0,        4,  1, 0, 1, 32'h4,        32'h0,        32'hCAFEF00D};
    vt[11] = '{LDRB_UOP, 32'h10A,      32'h1,  1'b1, 32'h0,        6,  1, 0, 1, 32'h108,      32'h0,        32'h00000056};
    vt[12] = '{LDR_UOP,  32'h10B,      32'h0,  1'b0, 32'h0,        2,  1, 0, 1, 32'h108,      32'h0,        32'h12345678};
    vt[13] = '{LDRB_UOP, 32'h108,      32'h0,  1'b0, 32'h0,        8,  1, 0, 1, 32'h108,      32'h0,        32'h00000078};

    drive(1, 1'b0, NOP_UOP, '0, '0, 1'b0, '0, '0);
    drive(3, 1'b0, NOP_UOP, '0, '0, 1'b0, '0, '0);
    repeat (3) @(negedge clock);

    chk("rst_in_ready",  32'(if1.in_ready), 32'd1);
    chk("rst_dc_uop",    32'(if1.dc_uop),   32'(NOP_UOP));
    chk("rst_dc_addr",   if1.dc_addr,       32'h0);
    chk("rst_dc_wdata",  if1.dc_wdata,      32'h0);
    chk("rst_wb_valid",  32'(if1.wb_valid), 32'd0);
    chk("rst_wb_rd",     32'(if1.wb_rd),    32'd0);
    chk("rst_wb_data",   if1.wb_data,       32'h0);
    chk("rst3_in_ready", 32'(if3.in_ready), 32'd1);
    chk("rst3_dc_uop",   32'(if3.dc_uop),   32'(NOP_UOP));
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 14; i++) run_vec(i);

    // LDR cycle-by-cycle timing, latency 1
    issue(1, LDR_UOP, 32'h108, 32'h0, 1'b0, 32'h0, 4'd10);
    chk("ldt_e0_uop",   32'(if1.dc_uop),   32'(LDR_UOP));
    chk("ldt_e0_ready", 32'(if1.in_ready), 32'd0);
    @(negedge clock);
    chk("ldt_e1_uop",   32'(if1.dc_uop),   32'(NOP_UOP));
    chk("ldt_e1_wbv",   32'(if1.wb_valid), 32'd0);
    @(negedge clock);
    chk("ldt_e2_wbv",   32'(if1.wb_valid), 32'd1);
    chk("ldt_e2_data",  if1.wb_data,       32'h12345678);
    chk("ldt_e2_rd",    32'(if1.wb_rd),    32'd10);
    @(negedge clock);
    chk("ldt_e3_wbv",   32'(if1.wb_valid), 32'd0);
    chk("ldt_e3_ready", 32'(if1.in_ready), 32'd1);
    chk("ldt_e3_hold",  if1.wb_data,       32'h12345678);

    // STR timing: one STR cycle, ready back after the next edge
    issue(1, STR_UOP, 32'h200, 32'h0, 1'b0, 32'h0BADCAFE, 4'd0);
    chk("stt_e0_uop",   32'(if1.dc_uop),   32'(STR_UOP));
    chk("stt_e0_wdata", if1.dc_wdata,      32'h0BADCAFE);
    chk("stt_e0_ready", 32'(if1.in_ready), 32'd0);
    @(negedge clock);
    chk("stt_e1_uop",   32'(if1.dc_uop),   32'(NOP_UOP));
    chk("stt_e1_ready", 32'(if1.in_ready), 32'd1);
    chk("stt_e1_wbv",   32'(if1.wb_valid), 32'd0);
    repeat (2) @(negedge clock);

    // Back-to-back: in_valid stays high, next uop waits for in_ready
    drive(1, 1'b1, LDR_UOP, 32'h200, 32'h0, 1'b0, 32'h0, 4'd2);
    @(negedge clock);
    drive(1, 1'b1, STR_UOP, 32'h300, 32'h0, 1'b0, 32'h5A5A5A5A, 4'd0);
    uops[0] = if1.dc_uop; rdys[0] = if1.in_ready;
    for (int k = 1; k < 6; k++) begin
      @(negedge clock);
      uops[k] = if1.dc_uop; rdys[k] = if1.in_ready;
      if (k == 2) chk("b2b_wbdata", if1.wb_data, 32'h0BADCAFE);
      if (k == 4) begin
        chk("b2b_st_addr", if1.dc_addr, 32'h300);
        drive(1, 1'b0, NOP_UOP, '0, '0, 1'b0, '0, '0);
      end
    end
    chk("b2b_n0_uop",   32'(uops[0]), 32'(LDR_UOP));
    chk("b2b_n1_uop",   32'(uops[1]), 32'(NOP_UOP));
    chk("b2b_n2_uop",   32'(uops[2]), 32'(NOP_UOP));
    chk("b2b_n3_uop",   32'(uops[3]), 32'(NOP_UOP));
    chk("b2b_n4_uop",   32'(uops[4]), 32'(STR_UOP));
    chk("b2b_n5_uop",   32'(uops[5]), 32'(NOP_UOP));
    chk("b2b_n2_ready", 32'(rdys[2]), 32'd0);
    chk("b2b_n3_ready", 32'(rdys[3]), 32'd1);
    chk("b2b_n4_ready", 32'(rdys[4]), 32'd0);
    repeat (2) @(negedge clock);

    // Reset during RMW_WAIT, latency 1
    s0 = st1;
    issue(1, STRB_UOP, 32'h40, 32'h0, 1'b0, 32'h99, 4'd0);
    chk("rmw1_e0_uop", 32'(if1.dc_uop), 32'(LDR_UOP));
    reset = 1'b1;
    @(negedge clock);
    chk("rmw1_rst_uop",   32'(if1.dc_uop),   32'(NOP_UOP));
    chk("rmw1_rst_ready", 32'(if1.in_ready), 32'd1);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("rmw1_nst",  32'(st1 - s0), 32'd0);
    chk("rmw1_word", mem1[16],      32'hAA11CCDD);

    // Latency 3 instance
    issue(3, STR_UOP, 32'h40, 32'h0, 1'b0, 32'h01020304, 4'd0);
    repeat (3) @(negedge clock);
    chk("l3_store", mem3[16], 32'h01020304);
    issue(3, LDR_UOP, 32'h40, 32'h0, 1'b0, 32'h0, 4'd11);
    repeat (3) @(negedge clock);
    chk("l3_e3_wbv", 32'(if3.wb_valid), 32'd0);
    @(negedge clock);
    chk("l3_e4_wbv",  32'(if3.wb_valid), 32'd1);
    chk("l3_e4_data", if3.wb_data,       32'h01020304);
    chk("l3_e4_rd",   32'(if3.wb_rd),    32'd11);
    repeat (3) @(negedge clock);

    s0 = st3;
    issue(3, STRB_UOP, 32'h41, 32'h0, 1'b0, 32'h77, 4'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rmw3_rst_uop",   32'(if3.dc_uop),   32'(NOP_UOP));
    chk("rmw3_rst_ready", 32'(if3.in_ready), 32'd1);
    chk("rmw3_rst_wbv",   32'(if3.wb_valid), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("rmw3_nst",  32'(st3 - s0), 32'd0);
    chk("rmw3_word", mem3[16],      32'h01020304);

    issue(3, STRB_UOP, 32'h41, 32'h0, 1'b0, 32'h77, 4'd0);
    repeat (8) @(negedge clock);
    chk("rmw3_full", mem3[16], 32'h01027704);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
